// File: rtl/ascon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ascon_pkg
// Description : Shared types, round counts, rotation amounts, round-constant
//               helper and FSM encodings for the iterative Ascon permutation.
// Revision    : 1.0 - initial release
// ============================================================================
package ascon_pkg;

  // x0 occupies the most significant word, matching the 320-bit port packing
  typedef struct packed {
    logic [63:0] x0;
    logic [63:0] x1;
    logic [63:0] x2;
    logic [63:0] x3;
    logic [63:0] x4;
  } ascon_state_t;

  localparam int NR_A = 12;

  // Linear-layer rotation pairs per word
  localparam int ROT_X0_A = 19;
  localparam int ROT_X0_B = 28;
  localparam int ROT_X1_A = 61;
  localparam int ROT_X1_B = 39;
  localparam int ROT_X2_A = 1;
  localparam int ROT_X2_B = 6;
  localparam int ROT_X3_A = 10;
  localparam int ROT_X3_B = 17;
  localparam int ROT_X4_A = 7;
  localparam int ROT_X4_B = 41;

  // FSM encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // p^b round count: Ascon-128 uses 6, Ascon-128a uses 8
  function automatic int nr_b(input int alg_ver);
    return (alg_ver == 2) ? 8 : 6;
  endfunction

  // Round constant: high nibble is the complement of the round index
  function automatic logic [7:0] round_const(input logic [3:0] r);
    return {4'hF - r, r};
  endfunction

  function automatic logic [63:0] rotr64(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

endpackage
`default_nettype wire

// File: rtl/ascon_round.sv
`default_nettype none
// ============================================================================
// Module      : ascon_round
// Description : One combinational Ascon round: constant addition, bit-sliced
//               5-bit S-box, linear diffusion layer.
// Revision    : 1.0 - initial release
// ============================================================================
module ascon_round
  import ascon_pkg::*;
(
  input  ascon_state_t i_state,
  input  logic [7:0]   i_c,
  output ascon_state_t o_state
);

  logic [63:0] w_c2;
  logic [63:0] w_p0, w_p2, w_p4;
  logic [63:0] w_t0, w_t1, w_t2, w_t3, w_t4;
  logic [63:0] w_k0, w_k1, w_k2, w_k3, w_k4;
  logic [63:0] w_s0, w_s1, w_s2, w_s3, w_s4;

  // Constant addition lands in the low byte of x2
  assign w_c2 = i_state.x2 ^ {56'd0, i_c};

  // S-box input mixing
  assign w_p0 = i_state.x0 ^ i_state.x4;
  assign w_p4 = i_state.x4 ^ i_state.x3;
  assign w_p2 = w_c2 ^ i_state.x1;

  // Chi-like nonlinear core
  assign w_t0 = ~w_p0       & i_state.x1;
  assign w_t1 = ~i_state.x1 & w_p2;
  assign w_t2 = ~w_p2       & i_state.x3;
  assign w_t3 = ~i_state.x3 & w_p4;
  assign w_t4 = ~w_p4       & w_p0;

  assign w_k0 = w_p0       ^ w_t1;
  assign w_k1 = i_state.x1 ^ w_t2;
  assign w_k2 = w_p2       ^ w_t3;
  assign w_k3 = i_state.x3 ^ w_t4;
  assign w_k4 = w_p4       ^ w_t0;

  // S-box output mixing
  assign w_s1 = w_k1 ^ w_k0;
  assign w_s0 = w_k0 ^ w_k4;
  assign w_s3 = w_k3 ^ w_k2;
  assign w_s2 = ~w_k2;
  assign w_s4 = w_k4;

  // Linear diffusion per word
  assign o_state.x0 = w_s0 ^ rotr64(w_s0, ROT_X0_A) ^ rotr64(w_s0, ROT_X0_B);
  assign o_state.x1 = w_s1 ^ rotr64(w_s1, ROT_X1_A) ^ rotr64(w_s1, ROT_X1_B);
  assign o_state.x2 = w_s2 ^ rotr64(w_s2, ROT_X2_A) ^ rotr64(w_s2, ROT_X2_B);
  assign o_state.x3 = w_s3 ^ rotr64(w_s3, ROT_X3_A) ^ rotr64(w_s3, ROT_X3_B);
  assign o_state.x4 = w_s4 ^ rotr64(w_s4, ROT_X4_A) ^ rotr64(w_s4, ROT_X4_B);

endmodule
`default_nettype wire

// File: rtl/ascon_perm_iter.sv
`default_nettype none
// ============================================================================
// Module      : ascon_perm_iter
// Description : Iterative handshaked Ascon permutation (p^a / p^b), UNROLL
//               rounds per clock. Optional abort port enabled by defining
//               ASCON_PERM_ABORT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ascon_perm_iter
  import ascon_pkg::*;
#(
  parameter int ALG_VER = 1,
  parameter int UNROLL  = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [319:0] in_state,
  input  logic         in_full,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [319:0] out_state,
`ifdef ASCON_PERM_ABORT_EN
  input  logic         abort,
`endif
  output logic         busy
);

  localparam int NR_B = nr_b(ALG_VER);

  generate
    if (UNROLL != 1 && UNROLL != 2) begin : g_bad_unroll
      $error("ascon_perm_iter: UNROLL must be 1 or 2");
    end
    if (ALG_VER != 1 && ALG_VER != 2) begin : g_bad_alg
      $error("ascon_perm_iter: ALG_VER must be 1 or 2");
    end
  endgenerate

  logic [1:0]   st_q, st_d;
  logic [3:0]   rnd_q, rnd_d;
  ascon_state_t state_q, state_d;
  ascon_state_t w_chain [UNROLL+1];
  logic         w_last;
  logic         w_abort;

`ifdef ASCON_PERM_ABORT_EN
  assign w_abort = abort && (st_q != ST_IDLE);
`else
  assign w_abort = 1'b0;
`endif

  // Round r and r+1 (when unrolled) are chained from the state register
  assign w_chain[0] = state_q;
  generate
    for (genvar gi = 0; gi < UNROLL; gi++) begin : g_round
      ascon_round u_round (
        .i_state (w_chain[gi]),
        .i_c     (round_const(rnd_q + 4'(gi))),
        .o_state (w_chain[gi+1])
      );
    end
  endgenerate

  assign w_last = (rnd_q == 4'(NR_A - UNROLL));

  // State, round counter and permutation register
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= ST_IDLE;
      rnd_q   <= 4'd0;
      state_q <= '0;
    end else begin
      st_q    <= st_d;
      rnd_q   <= rnd_d;
      state_q <= state_d;
    end
  end

  // Next-state: accept, run until the last round, release on consume
  always_comb begin
    st_d = st_q;
    case (st_q)
      ST_IDLE: if (in_valid)  st_d = ST_RUN;
      ST_RUN:  if (w_last)    st_d = ST_DONE;
      ST_DONE: if (out_ready) st_d = ST_IDLE;
      default:                st_d = ST_IDLE;
    endcase
    if (w_abort) st_d = ST_IDLE;
  end

  // Datapath: load on accept, advance UNROLL rounds per cycle in RUN
  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    if (!w_abort) begin
      if (st_q == ST_IDLE && in_valid) begin
        state_d = ascon_state_t'(in_state);
        rnd_d   = in_full ? 4'd0 : 4'(NR_A - NR_B);
      end else if (st_q == ST_RUN) begin
        state_d = w_chain[UNROLL];
        rnd_d   = rnd_q + 4'(UNROLL);
      end
    end
  end

  // Outputs decoded from the state register
  always_comb begin
    in_ready  = (st_q == ST_IDLE);
    out_valid = (st_q == ST_DONE);
    busy      = (st_q == ST_RUN) || (st_q == ST_DONE);
    out_state = state_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_ascon_perm_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ascon_perm_iter
// Description : Self-checking bench: two builds (ALG_VER=1/UNROLL=1 and
//               ALG_VER=2/UNROLL=2) driven in lockstep against a table-driven
//               Ascon reference model. Abort test when ASCON_PERM_ABORT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ascon_perm_iter;

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
  localparam int RA [5] = '{19, 61, 1, 10, 7};
  localparam int RB [5] = '{28, 39, 6, 17, 41};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [319:0] in_state = '0;
  logic         in_full = 1'b0;
  logic         out_ready = 1'b1;
  logic         abort = 1'b0;

  logic         a_in_ready, a_out_valid, a_busy;
  logic [319:0] a_out_state;
  logic         b_in_ready, b_out_valid, b_busy;
  logic [319:0] b_out_state;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ascon_perm_iter #(.ALG_VER(1), .UNROLL(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_state(in_state), .in_full(in_full), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_state(a_out_state),
`ifdef ASCON_PERM_ABORT_EN
    .abort(abort),
`endif
    .busy(a_busy));

  ascon_perm_iter #(.ALG_VER(2), .UNROLL(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_state(in_state), .in_full(in_full), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_state(b_out_state),
`ifdef ASCON_PERM_ABORT_EN
    .abort(abort),
`endif
    .busy(b_busy));

  task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Reference: rounds 12-nr .. 11, S-box applied column by column via table
  function automatic logic [319:0] ref_perm(input logic [319:0] s, input int nr);
    logic [63:0] x [5];
    logic [63:0] y [5];
    logic [4:0]  idx, o;
    logic [319:0] res;
    for (int i = 0; i < 5; i++) x[i] = s[319-64*i -: 64];
    for (int r = 12 - nr; r < 12; r++) begin
      x[2] = x[2] ^ 64'((15 - r) * 16 + r);
      for (int b = 0; b < 64; b++) begin
        idx = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
        o   = SBOX[idx];
        for (int i = 0; i < 5; i++) y[i][b] = o[4-i];
      end
      for (int i = 0; i < 5; i++) x[i] = y[i] ^ rotr(y[i], RA[i]) ^ rotr(y[i], RB[i]);
    end
    for (int i = 0; i < 5; i++) res[319-64*i -: 64] = x[i];
    return res;
  endfunction

  function automatic logic [319:0] rand320();
    logic [319:0] v;
    for (int i = 0; i < 10; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_a_rdy"},   a_in_ready,  1'b1);
    check({tag, "_a_vld"},   a_out_valid, 1'b0);
    check({tag, "_a_busy"},  a_busy,      1'b0);
    check({tag, "_b_rdy"},   b_in_ready,  1'b1);
    check({tag, "_b_vld"},   b_out_valid, 1'b0);
    check({tag, "_b_busy"},  b_busy,      1'b0);
  endtask

  // Issue a job to both builds and track each latency with out_ready high
  task automatic run_job(input logic [319:0] s, input logic full);
    int na, nb;
    logic [319:0] ea, eb;
    na = full ? 12 : 6;
    nb = full ? 6 : 4;
    ea = ref_perm(s, full ? 12 : 6);
    eb = ref_perm(s, full ? 12 : 8);
    @(negedge clk);
    in_state = s; in_full = full; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_state = rand320(); in_full = 1'($urandom);
    for (int k = 1; k <= na; k++) begin
      @(posedge clk); #1;
      check("a_valid_lat", a_out_valid, k == na);
      if (k <= nb) check("b_valid_lat", b_out_valid, k == nb);
      if (k == na) check("a_result", a_out_state, ea);
      if (k == nb) check("b_result", b_out_state, eb);
    end
    @(posedge clk); #1;
    check_idle("post_job");
  endtask

  initial begin
    logic [319:0] s, ea, eb;
    logic seen;

    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    check("reset_a_state", a_out_state, '0);
    check("reset_b_state", b_out_state, '0);
    @(negedge clk); rst = 1'b0;

    run_job('0, 1'b1);
    run_job('0, 1'b0);
    for (int j = 0; j < 24; j++) run_job(rand320(), 1'($urandom));

    // Output stall: both results held, requests refused
    s  = rand320();
    ea = ref_perm(s, 12);
    eb = ref_perm(s, 12);
    @(negedge clk);
    in_state = s; in_full = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("stall_a_vld", a_out_valid, 1'b1);
    check("stall_b_vld", b_out_valid, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = k[0]; in_state = rand320(); in_full = 1'($urandom);
      @(posedge clk); #1;
      check("stall_a_state", a_out_state, ea);
      check("stall_b_state", b_out_state, eb);
      check("stall_a_rdy",   a_in_ready,  1'b0);
      check("stall_b_rdy",   b_in_ready,  1'b0);
      check("stall_a_vld",   a_out_valid, 1'b1);
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check_idle("stall_release");
    check("stall_no_load", a_out_state, ea);
    @(posedge clk); #1;
    check_idle("stall_no_accept");

    // Reset at RUN cycle 4 of p^a
    @(negedge clk);
    in_state = rand320(); in_full = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check_idle("midrun_rst");
    check("midrun_rst_a_state", a_out_state, '0);
    check("midrun_rst_b_state", b_out_state, '0);
    @(negedge clk); rst = 1'b0;
    run_job(rand320(), 1'b1);

`ifdef ASCON_PERM_ABORT_EN
    // Abort at RUN cycle 2: no result, next job unaffected
    @(negedge clk);
    in_state = rand320(); in_full = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk); abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check_idle("abort");
    seen = 1'b0;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk); #1;
      if (a_out_valid || b_out_valid) seen = 1'b1;
    end
    check("abort_no_valid", seen, 1'b0);
    run_job(rand320(), 1'b1);
    run_job(rand320(), 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
